// File: rtl/ntt_lane_swap_permutation.sv
// Streaming inter-stage lane permutation for the pipelined NTT: out lane j takes in lane j with bits 0 and sel swapped.
// Optional macro STAGE_PERM_PIPE2_EN adds a second output register stage (latency 2 instead of 1).
module ntt_lane_swap_permutation #(
    parameter int DATA_WIDTH_PER_INPUT = 32,
    parameter int LOG_LANES            = 5,
    parameter int FRAME_CYCLES         = 128
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_start,
    input  logic [LOG_LANES-1:0]                                stage_sel,
    input  logic [(1<<LOG_LANES)*DATA_WIDTH_PER_INPUT-1:0]      in_data,
    output logic                                                out_start,
    output logic                                                out_valid,
    output logic [(1<<LOG_LANES)*DATA_WIDTH_PER_INPUT-1:0]      out_data,
    output logic                                                cfg_err
);

    localparam int LANES = 1 << LOG_LANES;
    localparam int W     = DATA_WIDTH_PER_INPUT;
    localparam int BUS_W = LANES * W;
    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
    localparam logic [LOG_LANES-1:0] SEL_LIMIT  = LOG_LANES'(LOG_LANES);
    localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(FRAME_CYCLES - 1);

    logic [LOG_LANES-1:0] r_sel_q;
    logic [CNT_W-1:0]     r_cnt;
    logic [BUS_W-1:0]     r_data;
    logic                 r_start;
    logic                 r_valid;
    logic                 r_cfg_err;

    logic [LOG_LANES-1:0] w_eff_sel;
    logic                 w_sel_bad;
    logic [BUS_W-1:0]     w_perm;

    // Select 0 and out-of-range selects match no swap bit, so they fall through to identity.
    function automatic logic [LOG_LANES-1:0] swap_idx(input logic [LOG_LANES-1:0] idx,
                                                      input logic [LOG_LANES-1:0] sel);
        logic [LOG_LANES-1:0] r;
        r = idx;
        for (int b = 1; b < LOG_LANES; b++) begin
            if (sel == LOG_LANES'(b)) begin
                r[0] = idx[b];
                r[b] = idx[0];
            end
        end
        return r;
    endfunction

    assign w_eff_sel = in_start ? stage_sel : r_sel_q;
    assign w_sel_bad = (w_eff_sel >= SEL_LIMIT);

    always_comb begin
        w_perm = '0;
        for (int j = 0; j < LANES; j++) begin
            w_perm[j*W +: W] = in_data[int'(swap_idx(LOG_LANES'(j), w_eff_sel))*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q   <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_start   <= 1'b0;
            r_valid   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_data  <= w_perm;
            r_start <= in_start;
            if (in_start) begin
                r_sel_q <= stage_sel;
                r_cnt   <= CNT_RELOAD;
                r_valid <= 1'b1;
                if (w_sel_bad) begin
                    r_cfg_err <= 1'b1;
                end
            end else if (r_cnt != '0) begin
                r_cnt   <= r_cnt - CNT_W'(1);
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef STAGE_PERM_PIPE2_EN
    logic [BUS_W-1:0] r_data2;
    logic             r_start2;
    logic             r_valid2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data2  <= '0;
            r_start2 <= 1'b0;
            r_valid2 <= 1'b0;
        end else begin
            r_data2  <= r_data;
            r_start2 <= r_start;
            r_valid2 <= r_valid;
        end
    end

    assign out_data  = r_data2;
    assign out_start = r_start2;
    assign out_valid = r_valid2;
`else
    assign out_data  = r_data;
    assign out_start = r_start;
    assign out_valid = r_valid;
`endif

    // Error flag reports on the cycle after sampling regardless of output pipeline depth.
    assign cfg_err = r_cfg_err;

endmodule
